// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types and defaults for the memory arbiter
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      IDLE,
      IACC,
      DRD,
      DWR
   } arb_state_t;

   localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/arb_timeout_ctr.sv
// arb_timeout_ctr: loadable/clearable up-counter with terminal-count flag
module arb_timeout_ctr #(
   parameter int WIDTH = 8,
   parameter int MAX   = 254
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             ld_i,
   input  logic [WIDTH-1:0] d_i,
   input  logic             en_i,
   output logic             tc_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   // clear wins over load, load wins over count
   always_comb begin
      cnt_d = clr_i ? '0 : ld_i ? d_i : en_i ? cnt_q + 1'b1 : cnt_q;
   end

   // count register
   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end

   assign tc_o = cnt_q == WIDTH'(MAX);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM sequencer for fetch and data requesters
// Optional fetch starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int TIMEOUT    = TIMEOUT_DEFAULT,
   parameter int STARVE_MAX = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        ihit,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dhit,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic        ramready,
   output logic        memerr
);

   localparam int TW = $clog2(TIMEOUT + 1);

   arb_state_t state_q, state_d;
   word_t      addr_q, addr_d;
   word_t      store_q, store_d;
   logic       err_q, err_d;
   logic       busy;
   logic       tmo_tc;
   logic       force_fetch;

   assign busy = state_q != IDLE;

   // the timeout counter sits at zero in IDLE, so every access starts fresh
   arb_timeout_ctr #(
      .WIDTH(TW),
      .MAX  (TIMEOUT - 1)
   ) u_tmo (
      .clk_i(CLK),
      .rst_i(RST),
      .clr_i(!busy),
      .ld_i (1'b0),
      .d_i  ('0),
      .en_i (busy && !ramready),
      .tc_o (tmo_tc)
   );

   // grant decision in IDLE, completion or abort in the access states
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      store_d = store_q;
      err_d   = err_q;
      if (!busy) begin
         state_d = force_fetch ? IACC : dWEN ? DWR : dREN ? DRD : iREN ? IACC : IDLE;
         addr_d  = state_d == IACC ? iaddr : state_d == IDLE ? addr_q : daddr;
         store_d = state_d == DWR ? dstore : store_q;
      end else if (ramready || tmo_tc) begin
         state_d = IDLE;
         err_d   = err_q || !ramready;
      end
   end

   // state, latched address/data and sticky error
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         addr_q  <= '0;
         store_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         store_q <= store_d;
         err_q   <= err_d;
      end
   end

`ifdef MEM_ARB_STARVE_GUARD_EN
   logic [2:0] starve_q, starve_d;

   assign force_fetch = iREN && starve_q >= 3'(STARVE_MAX);

   // counts data grants that overtook a pending fetch
   always_comb begin
      starve_d = starve_q;
      if (!busy && state_d == IACC) starve_d = '0;
      else if (!busy && (state_d == DRD || state_d == DWR) && iREN) starve_d = starve_q + 3'd1;
   end

   // starvation counter register
   always_ff @(posedge CLK) begin
      if (RST) starve_q <= '0;
      else starve_q <= starve_d;
   end
`else
   localparam int unused_starve_max = STARVE_MAX;

   assign force_fetch = 1'b0;
`endif

   assign ramREN   = state_q == IACC || state_q == DRD;
   assign ramWEN   = state_q == DWR;
   assign ramaddr  = addr_q;
   assign ramstore = store_q;
   assign memerr   = err_q;
   assign ihit     = state_q == IACC && ramready;
   assign dhit     = (state_q == DRD || state_q == DWR) && ramready;
   assign iload    = ihit ? ramload : '0;
   assign dload    = state_q == DRD && ramready ? ramload : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: cycle-by-cycle vector table plus guard sequence
module tb_mem_arbiter;

   typedef struct packed {
      logic        rst, iren, dren, dwen, rdy;
      logic [31:0] iaddr, daddr, dstore, rload;
   } in_t;

   typedef struct packed {
      logic        ih, dh, ren, wen, err;
      logic [31:0] iload, dload, raddr, rstore;
   } out_t;

   typedef struct {
      in_t  i;
      out_t e;
   } vec_t;

   logic        CLK = 0, RST = 1;
   logic        iREN = 0, dREN = 0, dWEN = 0, ramready = 0;
   logic [31:0] iaddr = 0, daddr = 0, dstore = 0, ramload = 0;
   logic        ihit, dhit, ramREN, ramWEN, memerr;
   logic [31:0] iload, dload, ramaddr, ramstore;

   int   checks = 0, errors = 0;
   vec_t tbl[$];
   out_t got;

   mem_arbiter #(.TIMEOUT(8)) dut (
      .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dhit(dhit), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramready(ramready), .memerr(memerr)
   );

   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic add(input in_t i, input out_t e);
      tbl.push_back('{i, e});
   endtask

   task automatic drive(input in_t i);
      RST = i.rst; iREN = i.iren; dREN = i.dren; dWEN = i.dwen; ramready = i.rdy;
      iaddr = i.iaddr; daddr = i.daddr; dstore = i.dstore; ramload = i.rload;
   endtask

   initial begin
      add('{1,0,0,0,0, 32'h0,   32'h0,   32'h0,        32'h0},        '{0,0,0,0,0, 32'h0,        32'h0,        32'h0,   32'h0});
      add('{0,1,0,0,0, 32'h40,  32'h0,   32'h0,        32'h0},        '{0,0,0,0,0, 32'h0,        32'h0,        32'h0,   32'h0});
      add('{0,1,0,0,0, 32'h40,  32'h0,   32'h0,        32'h0},        '{0,0,1,0,0, 32'h0,        32'h0,        32'h40,  32'h0});
      add('{0,1,0,0,0, 32'h40,  32'h0,   32'h0,        32'h0},        '{0,0,1,0,0, 32'h0,        32'h0,        32'h40,  32'h0});
      add('{0,1,0,0,1, 32'h40,  32'h0,   32'h0,        32'h8C220004}, '{1,0,1,0,0, 32'h8C220004, 32'h0,        32'h40,  32'h0});
      add('{0,0,0,0,1, 32'h0,   32'h0,   32'h0,        32'h8C220004}, '{0,0,0,0,0, 32'h0,        32'h0,        32'h40,  32'h0});
      add('{0,1,1,0,0, 32'h40,  32'h100, 32'h0,        32'h0},        '{0,0,0,0,0, 32'h0,        32'h0,        32'h40,  32'h0});
      add('{0,1,1,0,1, 32'h40,  32'h100, 32'h0,        32'h11111111}, '{0,1,1,0,0, 32'h0,        32'h11111111, 32'h100, 32'h0});
      add('{0,1,0,0,0, 32'h40,  32'h0,   32'h0,        32'h0},        '{0,0,0,0,0, 32'h0,        32'h0,        32'h100, 32'h0});
      add('{0,1,0,0,1, 32'h40,  32'h0,   32'h0,        32'h22222222}, '{1,0,1,0,0, 32'h22222222, 32'h0,        32'h40,  32'h0});
      add('{0,0,1,1,0, 32'h0,   32'h200, 32'hDEADBEEF, 32'h0},        '{0,0,0,0,0, 32'h0,        32'h0,        32'h40,  32'h0});
      add('{0,0,1,1,0, 32'h0,   32'h200, 32'h12345678, 32'h0},        '{0,0,0,1,0, 32'h0,        32'h0,        32'h200, 32'hDEADBEEF});
      add('{0,0,1,1,1, 32'h0,   32'h200, 32'h12345678, 32'h33333333}, '{0,1,0,1,0, 32'h0,        32'h0,        32'h200, 32'hDEADBEEF});
      add('{0,0,0,0,0, 32'h0,   32'h0,   32'h0,        32'h0},        '{0,0,0,0,0, 32'h0,        32'h0,        32'h200, 32'hDEADBEEF});
      add('{0,0,1,0,0, 32'h0,   32'h300, 32'h0,        32'h0},        '{0,0,0,0,0, 32'h0,        32'h0,        32'h200, 32'hDEADBEEF});
      repeat (8)
         add('{0,0,1,0,0, 32'h0, 32'h300, 32'h0,       32'h0},        '{0,0,1,0,0, 32'h0,        32'h0,        32'h300, 32'hDEADBEEF});
      add('{0,0,1,0,0, 32'h0,   32'h300, 32'h0,        32'h0},        '{0,0,0,0,1, 32'h0,        32'h0,        32'h300, 32'hDEADBEEF});
      add('{0,0,1,0,1, 32'h0,   32'h300, 32'h0,        32'h44444444}, '{0,1,1,0,1, 32'h0,        32'h44444444, 32'h300, 32'hDEADBEEF});
      add('{0,0,1,0,0, 32'h0,   32'h500, 32'h0,        32'h0},        '{0,0,0,0,1, 32'h0,        32'h0,        32'h300, 32'hDEADBEEF});
      add('{0,0,1,0,0, 32'h0,   32'h500, 32'h0,        32'h0},        '{0,0,1,0,1, 32'h0,        32'h0,        32'h500, 32'hDEADBEEF});
      add('{1,0,1,0,0, 32'h0,   32'h500, 32'h0,        32'h0},        '{0,0,1,0,1, 32'h0,        32'h0,        32'h500, 32'hDEADBEEF});
      add('{0,0,0,0,1, 32'h0,   32'h0,   32'h0,        32'h55555555}, '{0,0,0,0,0, 32'h0,        32'h0,        32'h0,   32'h0});
      add('{0,0,0,0,0, 32'h0,   32'h0,   32'h0,        32'h0},        '{0,0,0,0,0, 32'h0,        32'h0,        32'h0,   32'h0});
      add('{0,1,0,0,0, 32'h80,  32'h0,   32'h0,        32'h0},        '{0,0,0,0,0, 32'h0,        32'h0,        32'h0,   32'h0});
      add('{0,0,0,0,1, 32'h0,   32'h0,   32'h0,        32'h66666666}, '{1,0,1,0,0, 32'h66666666, 32'h0,        32'h80,  32'h0});
      add('{0,0,0,0,0, 32'h0,   32'h0,   32'h0,        32'h0},        '{0,0,0,0,0, 32'h0,        32'h0,        32'h80,  32'h0});

      RST = 1;
      repeat (2) @(posedge CLK);
      #1;
      for (int k = 0; k < tbl.size(); k++) begin
         drive(tbl[k].i);
         #4;
         got = '{ihit, dhit, ramREN, ramWEN, memerr, iload, dload, ramaddr, ramstore};
         checks++;
         if (got !== tbl[k].e) begin
            errors++;
            $display("FAIL vec%0d got ih=%b dh=%b ren=%b wen=%b err=%b il=%h dl=%h ra=%h rs=%h exp ih=%b dh=%b ren=%b wen=%b err=%b il=%h dl=%h ra=%h rs=%h",
                     k, got.ih, got.dh, got.ren, got.wen, got.err, got.iload, got.dload, got.raddr, got.rstore,
                     tbl[k].e.ih, tbl[k].e.dh, tbl[k].e.ren, tbl[k].e.wen, tbl[k].e.err,
                     tbl[k].e.iload, tbl[k].e.dload, tbl[k].e.raddr, tbl[k].e.rstore);
         end
         @(posedge CLK);
         #1;
      end

`ifdef MEM_ARB_STARVE_GUARD_EN
      begin : guard
         int dh;
         bit seen;
         dh = 0;
         seen = 0;
         RST = 0; iREN = 1; iaddr = 32'h40; dREN = 1; daddr = 32'h100; ramready = 1; ramload = 32'h77;
         for (int c = 0; c < 40 && !seen; c++) begin
            #4;
            if (ihit) seen = 1;
            else if (dhit) dh++;
            @(posedge CLK);
            #1;
         end
         checks++;
         if (!seen || dh != 4) begin
            errors++;
            $display("FAIL guard fetch_seen=%0b data_hits_before=%0d exp fetch_seen=1 data_hits_before=4", seen, dh);
         end
         iREN = 0; dREN = 0; ramready = 0;
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencing controller for the single shared RAM port. It sits between the datapath's instruction-fetch and data-access request lines and the unified memory. It grants one requester at a time, holds the address, data and strobes stable across a variable-latency RAM access, and returns a one-cycle `ihit`/`dhit` pulse with load data on completion. Data requests have priority, which matches the datapath rule that a data hit stalls fetch. An optional guard prevents instruction starvation.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum cycles spent in an access state waiting for `ramready` before the access is aborted.
- `STARVE_MAX`, default 4: consecutive data grants allowed while a fetch is pending. Used only with the guard compiled in.

Ports:
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `iREN` in 1: fetch request; held until `ihit`.
- `iaddr` in 32: fetch address.
- `ihit` out 1: one-cycle fetch completion pulse.
- `iload` out 32: fetched instruction; valid while `ihit`=1, else 0.
- `dREN` / `dWEN` in 1 / 1: data read / write request; held until `dhit`.
- `daddr` / `dstore` in 32 / 32: data address / store data.
- `dhit` out 1: one-cycle data completion pulse.
- `dload` out 32: load data; valid while `dhit`=1, else 0.
- `ramREN` / `ramWEN` out 1 / 1: RAM strobes.
- `ramaddr` / `ramstore` out 32 / 32: latched address / store data.
- `ramload` in 32: RAM read data.
- `ramready` in 1: RAM access complete this cycle.
- `memerr` out 1: sticky timeout flag.

## Operation
- States: IDLE, IACC, DRD, DWR.
- In IDLE, pending requests are sampled and the next state is picked in this priority:
  - `dWEN` → DWR.
  - `dREN` → DRD.
  - `iREN` → IACC.
  - No request → stay in IDLE.
- The grant also latches `ramaddr`, and `ramstore` for DWR.
- `dWEN` and `dREN` asserted together are treated as a write.
- In the access states:
  - `ramREN`=1 in IACC and DRD; `ramWEN`=1 in DWR. Both are decoded from registered state only.
  - `ramaddr` and `ramstore` stay constant for the whole access.
- Completion: `ramready`=1 in an access state pulses the matching hit in the same cycle, drives the load output from `ramload` (reads only), and returns to IDLE.
- Timeout counter:
  - Clears on entry to an access state and counts each cycle `ramready`=0.
  - At `TIMEOUT`, the access aborts to IDLE with no hit, and `memerr` sets and stays set until `RST`.
  - The requester still holds its request, so the access retries.
- A request dropped mid-access does not cancel the access. The hit still pulses and the requester ignores it.
- `ramready` in IDLE is ignored.

## Timing
- Reset values: state IDLE, all outputs 0, counters 0, `memerr` 0.
- Minimum latency is 2 cycles: a grant edge into the access state, then a `ramready` cycle with the hit. The controller always returns to IDLE, so back-to-back accesses are at least 2 cycles apart.
- Hits are combinational from registered state and `ramready`. Strobes are never combinational from request inputs.
- `RST` asserted mid-access: at the next edge, state goes to IDLE and the strobes drop. The in-flight result is discarded.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - A 3-bit counter increments on each data grant made while `iREN`=1.
  - It clears on any fetch grant.
  - When it reaches `STARVE_MAX`, the next IDLE decision grants IACC if `iREN`=1, regardless of data requests.
- Undefined: strict data priority, and no counter is instantiated.

## Structure
- The shared package (`cpu_types_pkg`) holds:
  - the `arb_state_t` enum (IDLE, IACC, DRD, DWR);
  - `word_t`;
  - the `TIMEOUT` default constant.
- One sub-module, `arb_timeout_ctr`: a loadable/clearable counter with a terminal-count output, reused for the timeout.
- The FSM, latches and output decode stay in `mem_arbiter`.

## Test plan
- **Fetch only:** `iREN`=1, `iaddr`=0x40; `ramready` high on the 3rd cycle after grant → `ramREN`=1 with `ramaddr`=0x40 throughout, `ihit` pulses one cycle with `iload`=`ramload`=0x8C220004.
- **Contention:** `iREN` and `dREN` both set in IDLE with `daddr`=0x100 → DRD granted first, `dhit` pulses, then IACC follows, then `ihit`.
- **Store:** `dWEN`=`dREN`=1, `dstore`=0xDEADBEEF → DWR; `ramWEN`=1, `ramREN`=0; `ramstore` stable until `ramready`; `dhit`=1 with `dload`=0.
- **Timeout:** `TIMEOUT`=8, `ramready` held 0 → abort after 8 cycles, `memerr`=1 sticky, no hit; `ramready` then set → retry completes.
- **Reset mid-DRD:** `RST` pulsed one cycle → next cycle all outputs 0 and state IDLE; an asserted `ramready` produces no hit.
- **Guard enabled:** `iREN` high with 5 consecutive data requests → IACC is granted after the 4th data access.
